// File: rtl/bf16_int_frac_arb.sv
// Round-robin arbiter that shares one bf16 floor/fraction converter among NREQ
// requesters and registers the result into a single backpressured response channel.

module bf16_to_int_frac (
    input  logic [15:0] x,
    output logic [31:0] int_part,
    output logic [15:0] frac_part
);
    logic [7:0] e;
    logic [7:0] m;
    logic [7:0] sh;
    logic [6:0] fbits;
    logic [2:0] p;

    assign e = x[14:7];
    assign m = {1'b1, x[6:0]};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        int_part  = '0;
        frac_part = '0;
        sh        = '0;
        fbits     = '0;
        p         = '0;
        if (x[15] || e == 8'd0) begin
            // negative or zero/denormal: flushed to 0.0
        end else if (e < 8'd127) begin
            frac_part = x;
        end else if (e < 8'd134) begin
            // sh mantissa bits remain below the binary point
            sh       = 8'd134 - e;
            int_part = 32'(m >> sh);
            fbits    = 7'(m & ((8'd1 << sh) - 8'd1));
            for (int i = 0; i < 7; i++) begin
                if (fbits[i]) p = 3'(i);
            end
            if (fbits != 7'd0)
                frac_part = {1'b0, 8'(e - 8'd7 + 8'(p)), 7'(fbits << (3'd7 - p))};
        end else begin
            // integral value; bits beyond 32 are truncated away
            int_part = 32'(m) << (e - 8'd134);
        end
    end
endmodule

module bf16_int_frac_arb #(
    parameter int NREQ = 4,
    parameter int TAGW = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_data,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [TAGW-1:0]      rsp_tag,
    output logic [31:0]          rsp_int,
    output logic [15:0]          rsp_frac,
    output logic [1:0]           rsp_flag,
    output logic [15:0]          acc_cnt,
    output logic                 busy
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr, win;
    logic            found, can_accept, accept;
    logic [15:0]     sel_data;
    logic [TAGW-1:0] sel_tag;
    logic [31:0]     cv_int;
    logic [15:0]     cv_frac;
    logic            flushed, overflow;
    int              idx;

    assign rsp_valid  = (state == FULL);
    assign busy       = rsp_valid;
    assign can_accept = !rsp_valid || rsp_ready;
    assign accept     = found && can_accept && !rst;

    // Rotating-priority search from rr_ptr; independent of req_ready.
    always_comb begin
        win      = '0;
        found    = 1'b0;
        sel_data = '0;
        sel_tag  = '0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                win      = IDW'(idx);
                sel_data = req_data[16*idx +: 16];
                sel_tag  = req_tag[TAGW*idx +: TAGW];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    bf16_to_int_frac u_conv (
        .x         (sel_data),
        .int_part  (cv_int),
        .frac_part (cv_frac)
    );

    assign flushed  = sel_data[15] || (sel_data[14:7] == 8'd0);
    assign overflow = !flushed && (sel_data[14:7] >= 8'd159);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        // NOTE: the response payload is reset too, so a discarded or idle channel always reads as zero.
        if (rst) begin
            rr_ptr   <= '0;
            acc_cnt  <= '0;
            rsp_id   <= '0;
            rsp_tag  <= '0;
            rsp_int  <= '0;
            rsp_frac <= '0;
            rsp_flag <= '0;
        end else if (accept) begin
            rr_ptr   <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
            rsp_id   <= win;
            rsp_tag  <= sel_tag;
            rsp_int  <= cv_int;
            rsp_frac <= cv_frac;
            rsp_flag <= {overflow, flushed};
            if (acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_bf16_int_frac_arb.sv
// Self-checking bench for bf16_int_frac_arb: directed plan items plus random traffic
// against a real-arithmetic reference model of the converter and arbiter.

module tb_bf16_int_frac_arb;
    localparam int NREQ = 4;
    localparam int TAGW = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*16-1:0]   req_data = '0;
    logic [NREQ*TAGW-1:0] req_tag = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [IDW-1:0]       rsp_id;
    logic [TAGW-1:0]      rsp_tag;
    logic [31:0]          rsp_int;
    logic [15:0]          rsp_frac;
    logic [1:0]           rsp_flag;
    logic [15:0]          acc_cnt;
    logic                 busy;

    bf16_int_frac_arb #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_int(rsp_int), .rsp_frac(rsp_frac), .rsp_flag(rsp_flag),
        .acc_cnt(acc_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_valid;
    int          m_id, m_tag, m_ptr, m_cnt;
    logic [31:0] m_int;
    logic [15:0] m_frac;
    logic [1:0]  m_flag;
    int          last_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // floor / fraction / flags computed with real arithmetic
    function automatic void ref_conv(input logic [15:0] x, output logic [31:0] ip,
                                     output logic [15:0] fp, output logic [1:0] fl);
        int          e;
        real         v, whole, fr;
        logic [63:0] db;
        e  = int'(x[14:7]);
        ip = '0;
        fp = '0;
        fl = '0;
        if (x[15] || e == 0) begin
            fl = 2'b01;
            return;
        end
        if (e >= 159) fl = 2'b10;
        v     = real'(128 + int'(x[6:0])) * (2.0 ** (e - 134));
        whole = $floor(v);
        fr    = v - whole;
        whole = whole - 4294967296.0 * $floor(whole / 4294967296.0);
        ip    = 32'(longint'(whole));
        if (fr != 0.0) begin
            db = $realtobits(fr);
            fp = {1'b0, 8'(int'(db[62:52]) - 1023 + 127), db[51:45]};
        end
    endfunction

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_tag = 0; m_ptr = 0; m_cnt = 0;
        m_int = '0; m_frac = '0; m_flag = '0;
    endtask

    // One clock: check grant, advance model at the edge, check registered outputs.
    task automatic cycle();
        int          w;
        logic [15:0] d;
        #1;
        w = -1;
        if (!rst && (!m_valid || rsp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
        end
        chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        @(posedge clk);
        last_w = rst ? -1 : w;
        if (rst) begin
            model_reset();
        end else if (w >= 0) begin
            d = req_data[16*w +: 16];
            ref_conv(d, m_int, m_frac, m_flag);
            m_valid = 1;
            m_id    = w;
            m_tag   = int'(req_tag[TAGW*w +: TAGW]);
            m_ptr   = (w + 1) % NREQ;
            if (m_cnt < 65535) m_cnt++;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("busy",      32'(busy),      32'(m_valid));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("rsp_tag",   32'(rsp_tag),   32'(m_tag));
        chk("rsp_int",   rsp_int,        m_int);
        chk("rsp_frac",  32'(rsp_frac),  32'(m_frac));
        chk("rsp_flag",  32'(rsp_flag),  32'(m_flag));
        chk("acc_cnt",   32'(acc_cnt),   32'(m_cnt));
    endtask

    function automatic logic [15:0] rand_bf16();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 1) == 0) v[14:7] = 8'($urandom_range(120, 165));
        return v;
    endfunction

    logic [15:0] dir_x   [6] = '{16'h4060, 16'h3F80, 16'h3F40, 16'hC000, 16'h4F00, 16'h4F80};
    logic [31:0] dir_int [6] = '{32'd3, 32'd1, 32'd0, 32'd0, 32'h8000_0000, 32'd0};
    logic [15:0] dir_frac[6] = '{16'h3F00, 16'h0000, 16'h3F40, 16'h0000, 16'h0000, 16'h0000};
    logic [1:0]  dir_flag[6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    int          rr_ids  [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        model_reset();
        last_w = -1;

        // reset, with requests pending: nothing may be accepted
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0; req_valid = '0;

        // directed values through requester 0; first one is the single-request case
        for (int i = 0; i < 6; i++) begin
            req_valid = 4'b0001;
            req_data[15:0] = dir_x[i];
            req_tag[3:0]   = 4'(i + 5);
            cycle();
            chk("dir_int",  rsp_int,         dir_int[i]);
            chk("dir_frac", 32'(rsp_frac),   32'(dir_frac[i]));
            chk("dir_flag", 32'(rsp_flag),   32'(dir_flag[i]));
            chk("dir_tag",  32'(rsp_tag),    32'(i + 5));
            if (i == 0) chk("first_acc_cnt", 32'(acc_cnt), 32'd1);
        end
        req_valid = '0;
        cycle();

        // round robin from pointer 0 with everyone valid
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[16*i +: 16] = 16'h4000 + 16'(i * 16'h0010);
            req_tag[TAGW*i +: TAGW] = 4'(i + 8);
        end
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_id", 32'(rsp_id), 32'(rr_ids[i]));
        end

        // backpressure: held response, no grants, then next requester on release
        rsp_ready = 1'b0;
        repeat (3) cycle();
        chk("bp_held_id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'b0100);
        cycle();

        // reset while full with requests pending, then requester 0 wins first
        rsp_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_full_valid", 32'(rsp_valid), 32'd0);
        chk("rst_full_cnt",   32'(acc_cnt),   32'd0);
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        cycle();

        // random traffic obeying the hold-until-accepted contract
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && last_w != i)) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_data[16*i +: 16] = rand_bf16();
                    req_tag[TAGW*i +: TAGW] = 4'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;

        // saturation of the accept counter
        rst = 1'b1;
        cycle();
        rst = 1'b0; rsp_ready = 1'b1; req_valid = '1;
        repeat (65540) cycle();
        chk("acc_cnt_sat", 32'(acc_cnt), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bf16_int_frac_arb.md
Name: bf16_int_frac_arb

Overview:
- Shares one bf16_to_int_frac converter among NREQ requesters using round-robin arbitration.
- Registers the converter outputs into a single response channel with one-cycle latency and full-throughput backpressure.
- Tags each response with requester id, a request tag and exception flags.
- Sits in front of the exp/softmax range-reduction path, where several vector lanes or scalar units need floor/fraction splits.

Parameters:
- NREQ, 4, number of requesters (2..16).
- TAGW, 4, width of the opaque per-request tag returned with the response.
- IDW, $clog2(NREQ), width of the requester id (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_data  in  NREQ*16  bf16 operands; requester i uses bits [16i+15:16i].
- req_tag  in  NREQ*TAGW  tags; requester i uses bits [TAGW*i+TAGW-1:TAGW*i].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the granted requester.
- rsp_tag  out  TAGW  tag echoed from the request.
- rsp_int  out  32  floor(x) as unsigned, taken from the converter.
- rsp_frac  out  16  x - floor(x) as bf16, taken from the converter.
- rsp_flag  out  2  bit0 = flushed (sign=1 or exp=0); bit1 = integer overflow (exp >= 8'd159, which includes inf/NaN).
- acc_cnt  out  16  count of accepted requests, saturating.
- busy  out  1  equals rsp_valid.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - rsp_valid=0; rsp_id, rsp_tag, rsp_int, rsp_frac, rsp_flag = 0;
  - round-robin pointer rr_ptr=0; acc_cnt=0.
- Reset mid-transfer discards any held response. No request is accepted on a cycle where rst=1 (req_ready=0).
- can_accept = !rsp_valid || rsp_ready.
- Arbitration is combinational:
  - Search req_valid starting at rr_ptr, ascending with wrap at NREQ-1 -> 0. The first set bit wins (index w).
  - req_ready[w] = can_accept && !rst. All other req_ready bits are 0. With no request, all bits are 0.
  - A grant never depends on req_ready (no combinational loop).
- Accept (req_valid[w] && req_ready[w] at the clk edge):
  - req_data[w] drives the single converter instance combinationally.
  - rsp_int, rsp_frac, rsp_flag, rsp_id<=w, rsp_tag<=req_tag[w] are captured.
  - rsp_valid<=1; rr_ptr<=(w+1) mod NREQ; acc_cnt<=acc_cnt+1 unless it is 16'hFFFF.
- Response FSM:
  - EMPTY (rsp_valid=0):
    - accept -> FULL;
    - else stay.
  - FULL (rsp_valid=1):
    - rsp_ready=1 and accept -> FULL, new data loaded in the same cycle (back-to-back, 1 result/cycle);
    - rsp_ready=1, no accept -> EMPTY;
    - rsp_ready=0 -> FULL, all rsp_* held stable and no accept.
- Latency: the response is visible the cycle after acceptance. Sustained throughput is 1 per cycle while rsp_ready=1.
- Requester contract: req_data and req_tag stay stable while req_valid=1 and not yet accepted. The arbiter does not buffer unaccepted requests.
- rr_ptr advances only on accept. A stalled or idle cycle never changes priority.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0. Any valid requester is granted within NREQ accepts.
- Flags are decoded from the accepted operand's exp/sign fields, not from converter outputs.
  - bit0 takes priority: if bit0=1 then bit1=0.
  - On overflow, rsp_int/rsp_frac pass through unchanged from the converter (truncated value). The consumer must use bit1.

Test Plan:
- Single request: req 0 sends 0x4060 (3.5), tag 5, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_tag=5, rsp_int=3, rsp_frac=0x3F00, rsp_flag=0, acc_cnt=1.
- Value directs: 0x3F80 -> int 1, frac 0x0000; 0x3F40 -> int 0, frac 0x3F40; 0xC000 -> int 0, frac 0, flag=2'b01; 0x4F00 -> int 0x80000000, flag=0; 0x4F80 -> flag=2'b10.
- All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one req_ready high per cycle, 6 responses in 6 cycles.
- Backpressure: rsp_ready=0 for 3 cycles while holding a response -> all req_ready=0, rsp_* stable, rr_ptr unchanged; rsp_ready=1 -> next requester granted the same cycle the held response drains.
- Reset in FULL with requests pending -> next cycle rsp_valid=0, acc_cnt=0; after rst drops, requester 0 wins first.
- Saturation: force 65536 accepts -> acc_cnt stays 16'hFFFF.
